stopwatch_ctrl: RTL and testbench

- Sequencing controller for a cascaded pair of two-digit BCD counters (centiseconds, low pair; seconds, high pair) that form a 00.00–99.99 stopwatch.
- Generates the counter enable (CE) from a clock prescaler.
- Issues counter clear pulses, implements start/stop and lap/reset button semantics, freezes the display value for lap times, and flags wrap-around.

---
 rtl/stopwatch_ctrl.sv | 127 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - sequencing controller for a 00.00-99.99 BCD stopwatch
//
// Purpose: runs the start/stop and lap/reset state machine, prescales the
// system clock into a count enable, issues the counter clear pulse, freezes
// the displayed value for lap times and flags wrap-around of the counters.
//
// Ports:
//   i_clk      system clock, all state on posedge
//   i_rst      asynchronous active-high reset
//   i_ss       start/stop request, single-cycle pulse
//   i_lr       lap/reset request, single-cycle pulse
//   i_cnt_in   live counter value {sec_tens, sec_ones, cs_tens, cs_ones}, BCD
//   i_cnt_up   carry-out of the high counter pair (99.99 -> 00.00 wrap)
//   o_ce_out   count enable to the low counter pair, one-cycle pulse
//   o_cnt_rst  registered clear pulse to both counter pairs
//   o_disp     value for the display driver, BCD
//   o_running  high in RUN and LAPRUN
//   o_lap      high while the display is frozen (LAPRUN)
//   o_ovf      sticky: counters wrapped since the last clear
module stopwatch_ctrl #(
  parameter int DIV  = 100000,
  parameter int DIVW = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ss,
  input  logic        i_lr,
  input  logic [15:0] i_cnt_in,
  input  logic        i_cnt_up,
  output logic        o_ce_out,
  output logic        o_cnt_rst,
  output logic [15:0] o_disp,
  output logic        o_running,
  output logic        o_lap,
  output logic        o_ovf
);

  localparam logic [DIVW-1:0] LP_LAST = DIVW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LAPRUN = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  state_t          r_state;
  logic [DIVW-1:0] r_presc;
  logic            r_cnt_rst;
  logic [15:0]     r_disp;
  logic            r_ovf;

  logic            w_active;
  logic            w_tick;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_LAPRUN);
  // A tick coinciding with a stopping SS is still issued; the state change
  // only lands on the following edge.
  assign w_tick   = w_active && (r_presc == LP_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_cnt_rst <= 1'b0;
      r_disp    <= 16'h0000;
      r_ovf     <= 1'b0;
    end else begin
      // Clear pulse is raised on the edge entering CLEAR so it is high for
      // exactly the CLEAR cycle.
      r_cnt_rst <= 1'b0;

      // SS is tested first everywhere so it wins over a simultaneous LR.
      case (r_state)
        ST_IDLE: begin
          if (i_ss) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_ss)      r_state <= ST_PAUSE;
          else if (i_lr) r_state <= ST_LAPRUN;
        end
        ST_LAPRUN: begin
          if (i_ss)      r_state <= ST_PAUSE;
          else if (i_lr) r_state <= ST_RUN;
        end
        ST_PAUSE: begin
          if (i_ss) begin
            r_state <= ST_RUN;
          end else if (i_lr) begin
            r_state   <= ST_CLEAR;
            r_cnt_rst <= 1'b1;
          end
        end
        ST_CLEAR: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      // PAUSE keeps the partial period so a resumed run is not short-changed.
      if (w_active) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end else if (r_state != ST_PAUSE) begin
        r_presc <= '0;
      end

      // Frozen only while LAPRUN is the current state; the RUN->LAPRUN edge
      // itself loads the lap value.
      if (r_state != ST_LAPRUN) begin
        r_disp <= i_cnt_in;
      end

      if (i_cnt_up) begin
        r_ovf <= 1'b1;
      end else if (r_state == ST_CLEAR) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_ce_out  = w_tick;
  assign o_cnt_rst = r_cnt_rst;
  assign o_disp    = r_disp;
  assign o_running = w_active;
  assign o_lap     = (r_state == ST_LAPRUN);
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic        clk;
  logic        rst;
  logic        ss;
  logic        lr;
  logic [15:0] cnt;
  logic        cnt_up;
  logic        ce;
  logic        cnt_rst;
  logic [15:0] disp;
  logic        running;
  logic        lap;
  logic        ovf;

  logic        load_req;
  logic [15:0] load_val;

  int n_tests;
  int n_fail;
  int ce_cnt;
  int ce_first;

  stopwatch_ctrl #(.DIV(4), .DIVW(3)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ss      (ss),
    .i_lr      (lr),
    .i_cnt_in  (cnt),
    .i_cnt_up  (cnt_up),
    .o_ce_out  (ce),
    .o_cnt_rst (cnt_rst),
    .o_disp    (disp),
    .o_running (running),
    .o_lap     (lap),
    .o_ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Cascaded BCD counter pair driven by the controller
  assign cnt_up = ce && (cnt == 16'h9999);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= 16'h0000;
    else if (load_req) cnt <= load_val;
    else if (cnt_rst)  cnt <= 16'h0000;
    else if (ce)       cnt <= bcd_inc(cnt);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    ss = 1'b1;
    step();
    ss = 1'b0;
  endtask

  task automatic pulse_lr();
    lr = 1'b1;
    step();
    lr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    ss       = 1'b0;
    lr       = 1'b0;
    load_req = 1'b0;
    load_val = 16'h0000;
    #1;
    rst = 1'b1;
    #1;
    check("rst_ce", ce, 1'b0);
    check("rst_cnt_rst", cnt_rst, 1'b0);
    check("rst_disp", disp, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_lap", lap, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();

    // LR is ignored in IDLE
    pulse_lr();
    check("idle_lr_running", running, 1'b0);
    check("idle_lr_lap", lap, 1'b0);

    // Start and tick cadence
    pulse_ss();
    check("run_running", running, 1'b1);
    check("run_ce0", ce, 1'b0);
    ce_cnt   = 0;
    ce_first = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (ce) begin
        ce_cnt++;
        if (ce_first == 0) ce_first = i;
      end
    end
    check("run_ce_count", 16'(ce_cnt), 16'd3);
    check("run_ce_first", 16'(ce_first), 16'd3);
    check("run_cnt12", cnt, 16'h0003);
    check("run_disp_lag", disp, 16'h0002);

    // Pause mid-period, then resume with the held partial tick
    step();
    pulse_ss();
    check("pause_running", running, 1'b0);
    ce_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ce) ce_cnt++;
    end
    check("pause_no_ce", 16'(ce_cnt), 16'd0);
    check("pause_cnt", cnt, 16'h0003);
    check("pause_disp", disp, 16'h0003);
    pulse_ss();
    check("resume_ce0", ce, 1'b0);
    step();
    check("resume_ce1", ce, 1'b1);
    step();
    check("resume_cnt", cnt, 16'h0004);

    // Lap freeze
    for (int i = 0; i < 100 && cnt != 16'h0012; i++) step();
    check("lap_reach", cnt, 16'h0012);
    pulse_lr();
    check("lap_on", lap, 1'b1);
    check("lap_running", running, 1'b1);
    check("lap_disp", disp, 16'h0012);
    repeat (8) step();
    check("lap_cnt_adv", cnt, 16'h0014);
    check("lap_disp_hold", disp, 16'h0012);
    pulse_lr();
    check("lap_off", lap, 1'b0);
    step();
    step();
    check("lap_disp_live", disp, 16'h0014);

    // Pause then clear
    pulse_ss();
    check("clr_paused", running, 1'b0);
    pulse_lr();
    check("clr_pulse_hi", cnt_rst, 1'b1);
    step();
    check("clr_pulse_lo", cnt_rst, 1'b0);
    check("clr_cnt", cnt, 16'h0000);
    check("clr_ovf", ovf, 1'b0);
    check("clr_idle_running", running, 1'b0);
    step();
    check("clr_disp", disp, 16'h0000);
    pulse_ss();
    repeat (4) step();
    check("restart_cnt", cnt, 16'h0001);

    // Wrap-around and sticky OVF
    pulse_ss();
    pulse_lr();
    step();
    load_req = 1'b1;
    load_val = 16'h9999;
    step();
    load_req = 1'b0;
    pulse_ss();
    repeat (3) step();
    check("wrap_cnt_up", cnt_up, 1'b1);
    step();
    check("wrap_cnt", cnt, 16'h0000);
    check("wrap_ovf", ovf, 1'b1);
    pulse_ss();
    repeat (3) step();
    check("wrap_ovf_pause", ovf, 1'b1);
    pulse_ss();
    step();
    check("wrap_ovf_resume", ovf, 1'b1);
    pulse_ss();
    pulse_lr();
    check("wrap_ovf_in_clear", ovf, 1'b1);
    step();
    check("wrap_ovf_cleared", ovf, 1'b0);

    // SS+LR together, then async reset mid-run
    load_req = 1'b1;
    load_val = 16'h9999;
    step();
    load_req = 1'b0;
    pulse_ss();
    repeat (10) step();
    check("both_pre_ovf", ovf, 1'b1);
    check("both_pre_disp", disp, 16'h0001);
    ss = 1'b1;
    lr = 1'b1;
    step();
    ss = 1'b0;
    lr = 1'b0;
    check("both_running", running, 1'b0);
    check("both_lap", lap, 1'b0);
    pulse_ss();
    check("both_resume_ce", ce, 1'b1);
    step();
    check("both_cnt", cnt, 16'h0002);
    step();
    step();
    check("arst_pre_disp", disp, 16'h0002);
    check("arst_pre_running", running, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_running", running, 1'b0);
    check("arst_lap", lap, 1'b0);
    check("arst_disp", disp, 16'h0000);
    check("arst_ovf", ovf, 1'b0);
    check("arst_ce", ce, 1'b0);
    check("arst_cnt_rst", cnt_rst, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("arst_idle", running, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
